// File: rtl/bcd_down_timer.sv
// Packed-BCD countdown timer: preload with per-digit saturation, start/pause
// control, tick-paced decrement and a one-cycle expiry pulse.
module bcd_down_timer #(
  parameter int DIGITS = 4
) (
  input  logic                  ck,
  input  logic                  rst_s,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  tick,
  output logic [4*DIGITS-1:0]   q,
  output logic                  running,
  output logic                  expired,
  output logic                  done,
  output logic                  zero
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, RUN, HOLD, EXPIRED} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d, cnt_dec;
  logic           running_q, running_d;
  logic           expired_q, expired_d;
  logic           done_q, done_d;

  function automatic logic [W-1:0] sat_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++)
      r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
    return r;
  endfunction

  // Borrow ripples through every digit in one cycle: 0 -> 9 keeps borrowing.
  function automatic logic [W-1:0] dec_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign cnt_dec = dec_bcd(cnt_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (load) begin
      cnt_d   = sat_bcd(load_val);
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (!pause && start && (cnt_q != '0)) state_d = RUN;
        RUN: begin
          if (pause) begin
            state_d = HOLD;
          end else if (tick) begin
            cnt_d = cnt_dec;
            if (cnt_dec == '0) begin
              state_d = EXPIRED;
              done_d  = 1'b1;
            end
          end
        end
        HOLD:    if (!pause && start) state_d = RUN;
        EXPIRED: state_d = EXPIRED;
        default: state_d = IDLE;
      endcase
    end
    running_d = (state_d == RUN);
    expired_d = (state_d == EXPIRED);
  end

  always_ff @(posedge ck or posedge rst_s) begin
    if (rst_s) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      expired_q <= expired_d;
      done_q    <= done_d;
    end
  end

  assign q       = cnt_q;
  assign running = running_q;
  assign expired = expired_q;
  assign done    = done_q;
  assign zero    = (cnt_q == '0);

endmodule

// File: tb/tb_bcd_down_timer.sv
// Bench for bcd_down_timer: directed scenarios plus random stimulus compared
// against an integer-valued countdown model.
module tb_bcd_down_timer;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic           ck = 1'b0;
  logic           rst_s = 1'b1;
  logic           load = 1'b0;
  logic [W-1:0]   load_val = '0;
  logic           start = 1'b0;
  logic           pause = 1'b0;
  logic           tick = 1'b0;
  logic [W-1:0]   q;
  logic           running, expired, done, zero;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: count held as a plain integer, mode as a small code.
  int m_val;
  int m_mode;   // 0 idle, 1 counting, 2 held, 3 expired
  bit m_done;

  bcd_down_timer #(.DIGITS(DIGITS)) dut (
    .ck(ck), .rst_s(rst_s), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .tick(tick),
    .q(q), .running(running), .expired(expired), .done(done), .zero(zero)
  );

  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat_int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      int d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r = r * 10 + d;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_val = 0; m_mode = 0; m_done = 0;
  endtask

  task automatic model_edge(input bit l, input logic [W-1:0] lv,
                            input bit s, input bit p, input bit t);
    m_done = 0;
    if (l) begin
      m_val = sat_int(lv); m_mode = 0;
    end else begin
      case (m_mode)
        0: if (!p && s && m_val != 0) m_mode = 1;
        1: if (p) m_mode = 2;
           else if (t) begin
             m_val = m_val - 1;
             if (m_val == 0) begin m_mode = 3; m_done = 1; end
           end
        2: if (!p && s) m_mode = 1;
        default: ;
      endcase
    end
  endtask

  task automatic chk_model();
    chk("q", q, to_bcd(m_val));
    chk("running", running, m_mode == 1);
    chk("expired", expired, m_mode == 3);
    chk("done", done, m_done);
    chk("zero", zero, m_val == 0);
  endtask

  task automatic cyc(input bit l, input logic [W-1:0] lv,
                     input bit s, input bit p, input bit t);
    load = l; load_val = lv; start = s; pause = p; tick = t;
    @(posedge ck);
    model_edge(l, lv, s, p, t);
    #1;
    load = 0; load_val = '0; start = 0; pause = 0; tick = 0;
    chk_model();
  endtask

  task automatic idle(); cyc(0, '0, 0, 0, 0); endtask

  initial begin
    model_reset();
    #2;
    chk("rst_q", q, 16'h0000);
    chk("rst_running", running, 1'b0);
    chk("rst_expired", expired, 1'b0);
    chk("rst_done", done, 1'b0);
    #10 rst_s = 1'b0;

    // Load 3, start, three spaced ticks down to expiry
    cyc(1, 16'h0003, 0, 0, 0);   chk("ld3", q, 16'h0003);
    cyc(0, '0, 1, 0, 0);         chk("start_run", running, 1'b1);
    cyc(0, '0, 0, 0, 1);         chk("t1", q, 16'h0002);
    idle();
    cyc(0, '0, 0, 0, 1);         chk("t2", q, 16'h0001); chk("t2_done", done, 1'b0);
    idle();
    cyc(0, '0, 0, 0, 1);         chk("t3", q, 16'h0000); chk("t3_done", done, 1'b1);
    chk("t3_exp", expired, 1'b1); chk("t3_run", running, 1'b0);
    cyc(0, '0, 1, 0, 1);         chk("done_clr", done, 1'b0); chk("exp_hold", expired, 1'b1);

    // Borrow ripple and saturation
    cyc(1, 16'h1000, 0, 0, 0);
    cyc(0, '0, 1, 0, 0);
    cyc(0, '0, 0, 0, 1);         chk("ripple", q, 16'h0999);
    cyc(1, 16'h0A5F, 0, 0, 0);   chk("sat", q, 16'h0959);

    // Pause priority and HOLD
    cyc(1, 16'h0010, 0, 0, 0);
    cyc(0, '0, 1, 0, 0);
    cyc(0, '0, 0, 0, 1);         chk("p_t", q, 16'h0009);
    cyc(0, '0, 0, 1, 1);         chk("p_pt", q, 16'h0009); chk("p_run", running, 1'b0);
    cyc(0, '0, 0, 0, 1);
    cyc(0, '0, 0, 0, 1);         chk("p_hold", q, 16'h0009);
    cyc(0, '0, 1, 0, 0);         chk("p_resume", running, 1'b1);
    cyc(0, '0, 0, 0, 1);         chk("p_after", q, 16'h0008);

    // Start edge tick not applied; start with zero ignored
    cyc(1, 16'h0005, 0, 0, 0);
    cyc(0, '0, 1, 0, 1);         chk("st_q", q, 16'h0005); chk("st_run", running, 1'b1);
    cyc(1, 16'h0000, 0, 0, 0);
    cyc(0, '0, 1, 0, 0);         chk("st0_run", running, 1'b0);

    // Load overrides RUN and EXPIRED
    cyc(1, 16'h0050, 0, 0, 0);
    cyc(0, '0, 1, 0, 0);
    cyc(1, 16'h0042, 0, 0, 1);   chk("ovr_q", q, 16'h0042); chk("ovr_run", running, 1'b0);
    cyc(1, 16'h0001, 0, 0, 0);
    cyc(0, '0, 1, 0, 0);
    cyc(0, '0, 0, 0, 1);         chk("exp_again", expired, 1'b1);
    cyc(1, 16'h0002, 0, 0, 0);   chk("exp_ld", expired, 1'b0);
    cyc(0, '0, 1, 0, 0);
    cyc(0, '0, 0, 0, 1);         chk("exp_resume", q, 16'h0001);

    // Asynchronous reset between edges while counting
    cyc(1, 16'h0123, 0, 0, 0);
    cyc(0, '0, 1, 0, 0);
    #3 rst_s = 1'b1;
    #1;
    chk("arst_q", q, 16'h0000);
    chk("arst_run", running, 1'b0);
    model_reset();
    #2 rst_s = 1'b0;
    idle();

    // Random stimulus
    for (int n = 0; n < 600; n++) begin
      bit l, s, p, t;
      logic [W-1:0] lv;
      l = ($urandom_range(0, 99) < 6);
      s = ($urandom_range(0, 99) < 25);
      p = ($urandom_range(0, 99) < 10);
      t = ($urandom_range(0, 99) < 55);
      if ($urandom_range(0, 1) == 1) lv = to_bcd($urandom_range(0, 25));
      else                           lv = W'($urandom);
      cyc(l, lv, s, p, t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_down_timer.md
# bcd_down_timer

Multi-digit BCD countdown timer with preload, start/pause control and an expiry pulse. It counts the opposite way to the team's BCD up-counter, so it drives display digits in the same packed BCD format the up-counter produces. It sits between the control FSM, which loads and starts the timer, and the display path, which consumes `q`. Decrements are paced by an external one-cycle `tick` strobe, so one clock domain serves any countdown rate.

## Interface
- `DIGITS`, default 4: number of BCD digits; digit 0 is least significant, `q[3:0]`.
- `ck`  in  1: clock; all state changes on rising edge.
- `rst_s`  in  1: reset, asynchronous and active-high.
- `load`  in  1: load `load_val` into the counter.
- `load_val`  in  4*DIGITS: preload value, packed BCD.
- `start`  in  1: begin or resume counting.
- `pause`  in  1: suspend counting.
- `tick`  in  1: decrement strobe, one cycle wide.
- `q`  out  4*DIGITS: current count, packed BCD, registered.
- `running`  out  1: high while in RUN, registered.
- `expired`  out  1: high while in EXPIRED, registered.
- `done`  out  1: one-cycle pulse on reaching zero, registered.
- `zero`  out  1: combinational, equals (`q` == 0).

## Operation
- **Reset** (async assert):
  - `q` = 0, state IDLE.
  - `running` = `expired` = `done` = 0.
  - Release takes effect on the next rising edge.
- **States:** IDLE, RUN, HOLD, EXPIRED.
- **Input priority per edge:** reset > `load` > `pause` > `start` > `tick`.
- **`load` (any state):**
  - `q` takes `load_val`; state goes to IDLE; `done` = 0.
  - Any `load_val` digit above 9 is saturated to 9, per digit, so `q` never holds a non-BCD digit.
- **IDLE:**
  - `start` with `q` != 0 goes to RUN.
  - `start` with `q` == 0 is ignored and the state stays IDLE.
  - `tick` and `pause` are ignored.
- **RUN:**
  - `pause` goes to HOLD with no decrement on that edge, even if `tick` = 1.
  - Otherwise `tick` decrements `q` by one in BCD:
    - A digit at 0 becomes 9 and borrows from the next digit.
    - A nonzero digit decrements by one and stops the borrow.
  - If the decrement makes `q` zero, the state goes to EXPIRED and `done` = 1 on that same edge.
  - `start` in RUN has no effect.
- **HOLD:**
  - `q` is frozen.
  - `start` (without `pause`) returns to RUN.
  - `tick` is ignored.
- **EXPIRED:**
  - `q` stays 0 and `expired` = 1.
  - `start`, `pause` and `tick` are ignored.
  - Only `load` or reset leave this state.
- **`done`** is high for exactly one cycle per expiry and is cleared on the following edge.
- **Underflow:** the counter never wraps below 0, because it reaches EXPIRED before any further decrement.

## Timing
- **Latency, one edge each:**
  - `load` to `q` valid.
  - `start` to `running` = 1.
  - `tick` to new `q`.
- **Start edge:** a `tick` asserted on the same edge as `start` (IDLE or HOLD to RUN) is not applied. The first decrement uses a `tick` sampled while `running` = 1.
- **Reaching zero:** `done`, `expired` = 1 and `running` = 0 all appear on the same edge that `q` becomes 0.
- **`zero`** follows `q` combinationally, with no added latency.
- **Borrow ripple:** completes within one cycle across all `DIGITS`, e.g. 1000 goes to 0999 in a single tick.
- **Reset mid-RUN:** asynchronous, so outputs clear without waiting for `ck`.

## Test plan
- **Reset and load:**
  - Stimulus: reset, load 0x0003, start, then 3 ticks spaced 2 cycles apart.
  - Required response: `q` = 3, 2, 1, 0; `done` high exactly one cycle, on the edge where `q` = 0; `expired` = 1 and `running` = 0 afterwards.
- **Borrow ripple and saturation:**
  - Stimulus: load 0x1000, start, 1 tick.
  - Required response: `q` = 0x0999.
  - Stimulus: load 0x0A5F.
  - Required response: `q` = 0x0959.
- **Pause and priority:**
  - Stimulus: load 0x0010, start, tick to 0x0009; then `pause` + `tick` together, 2 further ticks, then `start`, then 1 tick.
  - Required response: `q` holds 0x0009 through the pause and HOLD ticks, then reads 0x0008 after the resume tick.
- **Start edge and ignored starts:**
  - Stimulus: `start` + `tick` on the same edge after load 0x0005.
  - Required response: `q` stays 5 and `running` = 1.
  - Stimulus: `start` with `q` = 0 in IDLE.
  - Required response: `running` stays 0.
- **Load overrides:**
  - Stimulus: in RUN, `load` 0x0042 + `tick` together.
  - Required response: `q` = 0x0042, state IDLE, `running` = 0.
  - Stimulus: in EXPIRED, `load` 0x0002, then start.
  - Required response: `expired` = 0, then counting resumes.
- **Async reset:**
  - Stimulus: assert `rst_s` between clock edges while `q` = 0x0123 in RUN.
  - Required response: `q` = 0 and `running` = 0 before the next `ck` edge.
